// File: rtl/param_tx_framer.sv
// Frames a block of 32-bit words from a parameter RAM into a byte stream:
// SOF, 16-bit word count, payload (MSB first) and a two's-complement checksum.
module param_tx_framer #(
  parameter int          ADDR_W = 11,
  parameter int          DEPTH  = 1025,
  parameter logic [7:0]  SOF    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  input  logic [31:0]       ram_readdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  typedef enum logic [3:0] {
    IDLE, HDR_SOF, HDR_LHI, HDR_LLO, RD_REQ, RD_WAIT, DATA, CSUM, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        csum;
  logic [23:0]       word_sr;
  logic [1:0]        byte_idx;

  logic              xfer;
  logic [7:0]        csum_acc;
  logic [7:0]        csum_neg;
  logic [10:0]       cnt_hdr;
  logic              too_long;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    xfer      = tx_valid && tx_ready;
    // Running sum including the byte currently being accepted.
    csum_acc  = csum + tx_data;
    csum_neg  = 8'd0 - csum_acc;
    cnt_hdr   = 11'(cnt);
    too_long  = 32'(word_count) > 32'(DEPTH);
    addr_next = (rd_addr == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      rd_addr        <= '0;
      csum           <= '0;
      word_sr        <= '0;
      byte_idx       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (too_long) begin
              err <= 1'b1;
            end else begin
              cnt      <= word_count;
              rd_addr  <= base_addr;
              csum     <= '0;
              busy     <= 1'b1;
              tx_valid <= 1'b1;
              tx_data  <= SOF;
              state    <= HDR_SOF;
            end
          end
        end

        // SOF is excluded from the checksum.
        HDR_SOF: begin
          if (xfer) begin
            tx_data <= {5'b0, cnt_hdr[10:8]};
            state   <= HDR_LHI;
          end
        end

        HDR_LHI: begin
          if (xfer) begin
            csum    <= csum_acc;
            tx_data <= cnt_hdr[7:0];
            state   <= HDR_LLO;
          end
        end

        HDR_LLO: begin
          if (xfer) begin
            csum <= csum_acc;
            if (cnt == '0) begin
              tx_data <= csum_neg;
              state   <= CSUM;
            end else begin
              tx_valid       <= 1'b0;
              ram_chipselect <= 1'b1;
              ram_address    <= rd_addr;
              state          <= RD_REQ;
            end
          end
        end

        RD_REQ: begin
          ram_chipselect <= 1'b0;
          rd_addr        <= addr_next;
          state          <= RD_WAIT;
        end

        // First byte goes straight to tx_data; the rest wait in word_sr.
        RD_WAIT: begin
          tx_data  <= ram_readdata[31:24];
          word_sr  <= ram_readdata[23:0];
          byte_idx <= '0;
          tx_valid <= 1'b1;
          state    <= DATA;
        end

        DATA: begin
          if (xfer) begin
            csum <= csum_acc;
            if (byte_idx == 2'd3) begin
              cnt <= cnt - 1'b1;
              if (cnt == ADDR_W'(1)) begin
                tx_data <= csum_neg;
                state   <= CSUM;
              end else begin
                tx_valid       <= 1'b0;
                ram_chipselect <= 1'b1;
                ram_address    <= rd_addr;
                state          <= RD_REQ;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
              tx_data  <= word_sr[23:16];
              word_sr  <= {word_sr[15:0], 8'h00};
            end
          end
        end

        CSUM: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_tx_framer.sv
// Self-checking bench for param_tx_framer: frames are compared against a
// byte-list model built directly from the frame format and RAM contents.
module tb_param_tx_framer;

  localparam int         AW    = 11;
  localparam int         DEPTH = 1025;
  localparam logic [7:0] SOF   = 8'hA5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic          busy, done, err;
  logic [AW-1:0] ram_address;
  logic          ram_chipselect;
  logic [31:0]   ram_readdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;

  logic [31:0] mem [DEPTH];
  bit          rand_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  param_tx_framer #(.ADDR_W(AW), .DEPTH(DEPTH), .SOF(SOF)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_readdata   (ram_readdata),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM port.
  always @(posedge clk)
    if (ram_chipselect) ram_readdata <= mem[int'(ram_address) % DEPTH];

  always @(posedge clk) begin
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Passive monitor, sampled on the falling edge.
  byte unsigned got_q[$];
  int           rd_q[$];
  int           done_cnt = 0, busy_cnt = 0, err_cnt = 0, stab_err = 0, valid_nobusy = 0;
  bit           prev_stall = 1'b0;
  logic [7:0]   prev_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (ram_chipselect) rd_q.push_back(int'(ram_address));
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (tx_valid && !busy) valid_nobusy++;
      if (prev_stall && tx_valid && tx_data !== prev_data) stab_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  byte unsigned exp_q[$];

  task automatic build_frame(input int b, input int c);
    int sum;
    exp_q.delete();
    exp_q.push_back(SOF);
    exp_q.push_back(8'((c >> 8) & 7));
    exp_q.push_back(8'(c & 255));
    for (int i = 0; i < c; i++) begin
      logic [31:0] w;
      w = mem[(b + i) % DEPTH];
      for (int k = 3; k >= 0; k--) exp_q.push_back(8'((w >> (8 * k)) & 255));
    end
    sum = 0;
    for (int i = 1; i < exp_q.size(); i++) sum += int'(exp_q[i]);
    exp_q.push_back(8'((256 - (sum % 256)) % 256));
  endtask

  task automatic do_start(input int b, input int c);
    @(posedge clk); #1;
    base_addr  = AW'(b);
    word_count = AW'(c);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic run_frame(input int b, input int c, input string name,
                           input bit check_timing, input bit inject);
    int  g0, r0, d0, bu0, s0, e0, v0, first_bad, ng;
    bit  seen, bad;
    build_frame(b, c);
    g0 = got_q.size(); r0 = rd_q.size(); d0 = done_cnt; bu0 = busy_cnt;
    s0 = stab_err; e0 = err_cnt; v0 = valid_nobusy;
    do_start(b, c);
    if (inject) begin
      repeat (5) @(posedge clk);
      #1;
      base_addr  = AW'(7);
      word_count = AW'(1026);
      start      = 1'b1;
      @(posedge clk); #1;
      base_addr  = AW'(9);
      word_count = AW'(3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 20 * c + 200; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    @(negedge clk); @(negedge clk);

    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no done, required done within bound", name);
    end

    ng = got_q.size() - g0;
    bad = (ng != exp_q.size());
    first_bad = -1;
    for (int i = 0; i < exp_q.size() && i < ng; i++)
      if (got_q[g0 + i] !== exp_q[i] && first_bad < 0) begin first_bad = i; bad = 1'b1; end
    n_cmp++;
    if (bad) begin
      n_fail++;
      if (first_bad >= 0)
        $display("FAIL %s bytes: got len %0d byte[%0d]=%02h, required len %0d byte=%02h",
                 name, ng, first_bad, got_q[g0 + first_bad], exp_q.size(), exp_q[first_bad]);
      else
        $display("FAIL %s bytes: got len %0d, required len %0d", name, ng, exp_q.size());
    end

    bad = (rd_q.size() - r0 != c);
    for (int i = 0; i < c && (r0 + i) < rd_q.size(); i++)
      if (rd_q[r0 + i] != (b + i) % DEPTH) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s reads: got %0d reads, required %0d reads from %0d with wrap", name,
               rd_q.size() - r0, c, b);
    end

    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt - d0);
    end

    if (check_timing) begin
      n_cmp++;
      if (busy_cnt - bu0 != 4 + 6 * c) begin
        n_fail++;
        $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt - bu0, 4 + 6 * c);
      end
    end

    n_cmp++;
    if (stab_err - s0 != 0 || valid_nobusy - v0 != 0 || err_cnt - e0 != 0) begin
      n_fail++;
      $display("FAIL %s protocol: got stall_changes=%0d valid_without_busy=%0d err=%0d, required 0/0/0",
               name, stab_err - s0, valid_nobusy - v0, err_cnt - e0);
    end
  endtask

  task automatic test_reset();
    int g0;
    apply_reset();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    n_cmp++; if (ram_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b, required 0", ram_chipselect); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data); end
    n_cmp++; if (ram_address !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", ram_address); end
    g0 = got_q.size();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (got_q.size() != g0) begin n_fail++; $display("FAIL reset_idle_bytes: got %0d, required 0", got_q.size() - g0); end
  endtask

  task automatic test_basic();
    mem[5] = 32'h11223344;
    run_frame(5, 1, "basic", 1'b1, 1'b0);
    n_cmp++;
    if (exp_q[exp_q.size() - 1] !== 8'h55 || got_q[got_q.size() - 1] !== 8'h55) begin
      n_fail++;
      $display("FAIL basic_csum: got %02h, required 55", got_q[got_q.size() - 1]);
    end
  endtask

  task automatic test_zero_count();
    run_frame(123, 0, "zero_count", 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    mem[1024] = 32'h01020304;
    mem[0]    = 32'h05060708;
    run_frame(1024, 2, "wrap", 1'b1, 1'b0);
    n_cmp++;
    if (got_q[got_q.size() - 1] !== 8'hDA) begin
      n_fail++;
      $display("FAIL wrap_csum: got %02h, required DA", got_q[got_q.size() - 1]);
    end
  endtask

  task automatic test_random_frames();
    int b, c;
    for (int n = 0; n < 6; n++) begin
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(0, 6);
      rand_ready = 1'b0;
      run_frame(b, c, "rand_ready1", 1'b1, 1'b0);
      rand_ready = 1'b1;
      run_frame(b, c, "rand_backpressure", 1'b0, 1'b0);
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_max_count();
    run_frame($urandom_range(0, DEPTH - 1), DEPTH, "max_count", 1'b1, 1'b0);
  endtask

  task automatic test_err();
    int e0, bu0, g0;
    int bad_counts[2] = '{1026, 2047};
    foreach (bad_counts[i]) begin
      e0 = err_cnt; bu0 = busy_cnt; g0 = got_q.size();
      do_start(3, bad_counts[i]);
      repeat (6) @(negedge clk);
      n_cmp++;
      if (err_cnt - e0 != 1 || busy_cnt != bu0 || got_q.size() != g0) begin
        n_fail++;
        $display("FAIL err_reject_%0d: got err=%0d busy_cycles=%0d bytes=%0d, required 1/0/0",
                 bad_counts[i], err_cnt - e0, busy_cnt - bu0, got_q.size() - g0);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_frame(40, 3, "start_during_busy", 1'b1, 1'b1);
    run_frame(41, 1, "back_to_back", 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int  g0;
    bit  hit;
    mem[20] = $urandom; mem[21] = $urandom;
    rand_ready = 1'b0;
    g0 = got_q.size();
    do_start(20, 2);
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (got_q.size() - g0 == 4 && tx_valid) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (!hit) begin n_fail++; $display("FAIL reset_mid_reach: got no 2nd data byte, required it within 50 cycles"); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || ram_chipselect !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got tx_valid=%b busy=%b cs=%b, required 0/0/0",
               tx_valid, busy, ram_chipselect);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    g0 = got_q.size();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (got_q.size() != g0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got %0d bytes busy=%b, required 0 bytes busy=0", got_q.size() - g0, busy);
    end
    run_frame(20, 2, "after_reset", 1'b1, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_random_frames();
    test_err();
    test_back_to_back();
    test_max_count();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
